// File: rtl/key_exp.sv
// key_exp: iterative AES key expansion for AES-128/192/256 (nk = 4/6/8).
// Each start loads the key words. Every later cycle then appends four schedule
// words until all NW = 4*(nr+1) words are present.
// Optional feature macro: KEYEXP_CLEAR_ON_RESTART_EN. When it is defined,
// words nk..NW-1 are zeroed at every start.

module key_exp_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    // Forward AES S-box as a flat lookup table
    always_comb begin
        s_o = 8'h00;
        case (a_i)
            8'h00: s_o = 8'h63; 8'h01: s_o = 8'h7c; 8'h02: s_o = 8'h77; 8'h03: s_o = 8'h7b; 8'h04: s_o = 8'hf2; 8'h05: s_o = 8'h6b; 8'h06: s_o = 8'h6f; 8'h07: s_o = 8'hc5;
            8'h08: s_o = 8'h30; 8'h09: s_o = 8'h01; 8'h0a: s_o = 8'h67; 8'h0b: s_o = 8'h2b; 8'h0c: s_o = 8'hfe; 8'h0d: s_o = 8'hd7; 8'h0e: s_o = 8'hab; 8'h0f: s_o = 8'h76;
            8'h10: s_o = 8'hca; 8'h11: s_o = 8'h82; 8'h12: s_o = 8'hc9; 8'h13: s_o = 8'h7d; 8'h14: s_o = 8'hfa; 8'h15: s_o = 8'h59; 8'h16: s_o = 8'h47; 8'h17: s_o = 8'hf0;
            8'h18: s_o = 8'had; 8'h19: s_o = 8'hd4; 8'h1a: s_o = 8'ha2; 8'h1b: s_o = 8'haf; 8'h1c: s_o = 8'h9c; 8'h1d: s_o = 8'ha4; 8'h1e: s_o = 8'h72; 8'h1f: s_o = 8'hc0;
            8'h20: s_o = 8'hb7; 8'h21: s_o = 8'hfd; 8'h22: s_o = 8'h93; 8'h23: s_o = 8'h26; 8'h24: s_o = 8'h36; 8'h25: s_o = 8'h3f; 8'h26: s_o = 8'hf7; 8'h27: s_o = 8'hcc;
            8'h28: s_o = 8'h34; 8'h29: s_o = 8'ha5; 8'h2a: s_o = 8'he5; 8'h2b: s_o = 8'hf1; 8'h2c: s_o = 8'h71; 8'h2d: s_o = 8'hd8; 8'h2e: s_o = 8'h31; 8'h2f: s_o = 8'h15;
            8'h30: s_o = 8'h04; 8'h31: s_o = 8'hc7; 8'h32: s_o = 8'h23; 8'h33: s_o = 8'hc3; 8'h34: s_o = 8'h18; 8'h35: s_o = 8'h96; 8'h36: s_o = 8'h05; 8'h37: s_o = 8'h9a;
            8'h38: s_o = 8'h07; 8'h39: s_o = 8'h12; 8'h3a: s_o = 8'h80; 8'h3b: s_o = 8'he2; 8'h3c: s_o = 8'heb; 8'h3d: s_o = 8'h27; 8'h3e: s_o = 8'hb2; 8'h3f: s_o = 8'h75;
            8'h40: s_o = 8'h09; 8'h41: s_o = 8'h83; 8'h42: s_o = 8'h2c; 8'h43: s_o = 8'h1a; 8'h44: s_o = 8'h1b; 8'h45: s_o = 8'h6e; 8'h46: s_o = 8'h5a; 8'h47: s_o = 8'ha0;
            8'h48: s_o = 8'h52; 8'h49: s_o = 8'h3b; 8'h4a: s_o = 8'hd6; 8'h4b: s_o = 8'hb3; 8'h4c: s_o = 8'h29; 8'h4d: s_o = 8'he3; 8'h4e: s_o = 8'h2f; 8'h4f: s_o = 8'h84;
            8'h50: s_o = 8'h53; 8'h51: s_o = 8'hd1; 8'h52: s_o = 8'h00; 8'h53: s_o = 8'hed; 8'h54: s_o = 8'h20; 8'h55: s_o = 8'hfc; 8'h56: s_o = 8'hb1; 8'h57: s_o = 8'h5b;
            8'h58: s_o = 8'h6a; 8'h59: s_o = 8'hcb; 8'h5a: s_o = 8'hbe; 8'h5b: s_o = 8'h39; 8'h5c: s_o = 8'h4a; 8'h5d: s_o = 8'h4c; 8'h5e: s_o = 8'h58; 8'h5f: s_o = 8'hcf;
            8'h60: s_o = 8'hd0; 8'h61: s_o = 8'hef; 8'h62: s_o = 8'haa; 8'h63: s_o = 8'hfb; 8'h64: s_o = 8'h43; 8'h65: s_o = 8'h4d; 8'h66: s_o = 8'h33; 8'h67: s_o = 8'h85;
            8'h68: s_o = 8'h45; 8'h69: s_o = 8'hf9; 8'h6a: s_o = 8'h02; 8'h6b: s_o = 8'h7f; 8'h6c: s_o = 8'h50; 8'h6d: s_o = 8'h3c; 8'h6e: s_o = 8'h9f; 8'h6f: s_o = 8'ha8;
            8'h70: s_o = 8'h51; 8'h71: s_o = 8'ha3; 8'h72: s_o = 8'h40; 8'h73: s_o = 8'h8f; 8'h74: s_o = 8'h92; 8'h75: s_o = 8'h9d; 8'h76: s_o = 8'h38; 8'h77: s_o = 8'hf5;
            8'h78: s_o = 8'hbc; 8'h79: s_o = 8'hb6; 8'h7a: s_o = 8'hda; 8'h7b: s_o = 8'h21; 8'h7c: s_o = 8'h10; 8'h7d: s_o = 8'hff; 8'h7e: s_o = 8'hf3; 8'h7f: s_o = 8'hd2;
            8'h80: s_o = 8'hcd; 8'h81: s_o = 8'h0c; 8'h82: s_o = 8'h13; 8'h83: s_o = 8'hec; 8'h84: s_o = 8'h5f; 8'h85: s_o = 8'h97; 8'h86: s_o = 8'h44; 8'h87: s_o = 8'h17;
            8'h88: s_o = 8'hc4; 8'h89: s_o = 8'ha7; 8'h8a: s_o = 8'h7e; 8'h8b: s_o = 8'h3d; 8'h8c: s_o = 8'h64; 8'h8d: s_o = 8'h5d; 8'h8e: s_o = 8'h19; 8'h8f: s_o = 8'h73;
            8'h90: s_o = 8'h60; 8'h91: s_o = 8'h81; 8'h92: s_o = 8'h4f; 8'h93: s_o = 8'hdc; 8'h94: s_o = 8'h22; 8'h95: s_o = 8'h2a; 8'h96: s_o = 8'h90; 8'h97: s_o = 8'h88;
            8'h98: s_o = 8'h46; 8'h99: s_o = 8'hee; 8'h9a: s_o = 8'hb8; 8'h9b: s_o = 8'h14; 8'h9c: s_o = 8'hde; 8'h9d: s_o = 8'h5e; 8'h9e: s_o = 8'h0b; 8'h9f: s_o = 8'hdb;
            8'ha0: s_o = 8'he0; 8'ha1: s_o = 8'h32; 8'ha2: s_o = 8'h3a; 8'ha3: s_o = 8'h0a; 8'ha4: s_o = 8'h49; 8'ha5: s_o = 8'h06; 8'ha6: s_o = 8'h24; 8'ha7: s_o = 8'h5c;
            8'ha8: s_o = 8'hc2; 8'ha9: s_o = 8'hd3; 8'haa: s_o = 8'hac; 8'hab: s_o = 8'h62; 8'hac: s_o = 8'h91; 8'had: s_o = 8'h95; 8'hae: s_o = 8'he4; 8'haf: s_o = 8'h79;
            8'hb0: s_o = 8'he7; 8'hb1: s_o = 8'hc8; 8'hb2: s_o = 8'h37; 8'hb3: s_o = 8'h6d; 8'hb4: s_o = 8'h8d; 8'hb5: s_o = 8'hd5; 8'hb6: s_o = 8'h4e; 8'hb7: s_o = 8'ha9;
            8'hb8: s_o = 8'h6c; 8'hb9: s_o = 8'h56; 8'hba: s_o = 8'hf4; 8'hbb: s_o = 8'hea; 8'hbc: s_o = 8'h65; 8'hbd: s_o = 8'h7a; 8'hbe: s_o = 8'hae; 8'hbf: s_o = 8'h08;
            8'hc0: s_o = 8'hba; 8'hc1: s_o = 8'h78; 8'hc2: s_o = 8'h25; 8'hc3: s_o = 8'h2e; 8'hc4: s_o = 8'h1c; 8'hc5: s_o = 8'ha6; 8'hc6: s_o = 8'hb4; 8'hc7: s_o = 8'hc6;
            8'hc8: s_o = 8'he8; 8'hc9: s_o = 8'hdd; 8'hca: s_o = 8'h74; 8'hcb: s_o = 8'h1f; 8'hcc: s_o = 8'h4b; 8'hcd: s_o = 8'hbd; 8'hce: s_o = 8'h8b; 8'hcf: s_o = 8'h8a;
            8'hd0: s_o = 8'h70; 8'hd1: s_o = 8'h3e; 8'hd2: s_o = 8'hb5; 8'hd3: s_o = 8'h66; 8'hd4: s_o = 8'h48; 8'hd5: s_o = 8'h03; 8'hd6: s_o = 8'hf6; 8'hd7: s_o = 8'h0e;
            8'hd8: s_o = 8'h61; 8'hd9: s_o = 8'h35; 8'hda: s_o = 8'h57; 8'hdb: s_o = 8'hb9; 8'hdc: s_o = 8'h86; 8'hdd: s_o = 8'hc1; 8'hde: s_o = 8'h1d; 8'hdf: s_o = 8'h9e;
            8'he0: s_o = 8'he1; 8'he1: s_o = 8'hf8; 8'he2: s_o = 8'h98; 8'he3: s_o = 8'h11; 8'he4: s_o = 8'h69; 8'he5: s_o = 8'hd9; 8'he6: s_o = 8'h8e; 8'he7: s_o = 8'h94;
            8'he8: s_o = 8'h9b; 8'he9: s_o = 8'h1e; 8'hea: s_o = 8'h87; 8'heb: s_o = 8'he9; 8'hec: s_o = 8'hce; 8'hed: s_o = 8'h55; 8'hee: s_o = 8'h28; 8'hef: s_o = 8'hdf;
            8'hf0: s_o = 8'h8c; 8'hf1: s_o = 8'ha1; 8'hf2: s_o = 8'h89; 8'hf3: s_o = 8'h0d; 8'hf4: s_o = 8'hbf; 8'hf5: s_o = 8'he6; 8'hf6: s_o = 8'h42; 8'hf7: s_o = 8'h68;
            8'hf8: s_o = 8'h41; 8'hf9: s_o = 8'h99; 8'hfa: s_o = 8'h2d; 8'hfb: s_o = 8'h0f; 8'hfc: s_o = 8'hb0; 8'hfd: s_o = 8'h54; 8'hfe: s_o = 8'hbb; 8'hff: s_o = 8'h16;
        endcase
    end
endmodule

module key_exp #(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [nk*32-1:0]      key,
    output logic [128*(nr+1)-1:0] w,
    output logic                  valid
);
    localparam int NW = 4 * (nr + 1);
    localparam int IW = $clog2(NW + 4) + 1;
    localparam logic [IW-1:0] NKW = IW'(nk);
    localparam logic [IW-1:0] NWW = IW'(NW);

    logic [31:0]      w_q [NW];
    logic [31:0]      w_d [NW];
    logic [nk*32-1:0] key_q;
    logic [IW-1:0]    idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             pend_q;
    logic             start, busy;

    // Group word indices and the two substitution slots.
    // Slot 0 serves word idx and slot 1 serves word idx+2. For every legal nk,
    // idx runs nk, nk+4, ..., so the words that need SubWord can only fall on
    // those two positions.
    logic [IW-1:0] wi [4];
    logic          rot0, sub0, rot2, sub2;
    logic [7:0]    rc0, rc2;
    logic [31:0]   tprev, sb_in0, sb_out0, sb_in1, sb_out1;
    logic [31:0]   nw0, nw1, nw2, nw3;

    assign start = pend_q || (key != key_q);
    assign busy  = idx_q < NWW;

    function automatic logic [31:0] rd(input logic [IW-1:0] i);
        rd = 32'h0;
        for (int j = 0; j < NW; j++) if (IW'(j) == i) rd = w_q[j];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] rotw(input logic [31:0] x);
        rotw = {x[23:0], x[31:24]};
    endfunction

    // Slot decode and the first S-box input, which depend only on registered state
    always_comb begin
        for (int k = 0; k < 4; k++) wi[k] = idx_q + IW'(k);
        rot0   = (wi[0] % NKW) == '0;
        sub0   = (nk == 8) && ((wi[0] % NKW) == IW'(4));
        rc0    = rcon(4'(wi[0] / NKW));
        rot2   = (wi[2] % NKW) == '0;
        sub2   = (nk == 8) && ((wi[2] % NKW) == IW'(4));
        rc2    = rcon(4'(wi[2] / NKW));
        tprev  = rd(idx_q - IW'(1));
        sb_in0 = rot0 ? rotw(tprev) : tprev;
    end

    // Words idx and idx+1, plus the second S-box input
    always_comb begin
        if (rot0)      nw0 = rd(wi[0] - NKW) ^ sb_out0 ^ {rc0, 24'h0};
        else if (sub0) nw0 = rd(wi[0] - NKW) ^ sb_out0;
        else           nw0 = rd(wi[0] - NKW) ^ tprev;
        nw1    = rd(wi[1] - NKW) ^ nw0;
        sb_in1 = rot2 ? rotw(nw1) : nw1;
    end

    // Words idx+2 and idx+3
    always_comb begin
        if (rot2)      nw2 = rd(wi[2] - NKW) ^ sb_out1 ^ {rc2, 24'h0};
        else if (sub2) nw2 = rd(wi[2] - NKW) ^ sb_out1;
        else           nw2 = rd(wi[2] - NKW) ^ nw1;
        nw3 = rd(wi[3] - NKW) ^ nw2;
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        key_exp_sbox u_sb0 (.a_i(sb_in0[b*8 +: 8]), .s_o(sb_out0[b*8 +: 8]));
        key_exp_sbox u_sb1 (.a_i(sb_in1[b*8 +: 8]), .s_o(sb_out1[b*8 +: 8]));
    end

    // Next state: a start beats the expansion step; writes at or past NW are dropped
    always_comb begin
        w_d     = w_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (start) begin
            for (int j = 0; j < nk; j++) w_d[j] = key[(nk-1-j)*32 +: 32];
`ifdef KEYEXP_CLEAR_ON_RESTART_EN
            for (int j = nk; j < NW; j++) w_d[j] = 32'h0;
`endif
            idx_d   = NKW;
            valid_d = 1'b0;
        end else if (busy) begin
            for (int j = 0; j < NW; j++) begin
                if (IW'(j) == wi[0]) w_d[j] = nw0;
                if (IW'(j) == wi[1]) w_d[j] = nw1;
                if (IW'(j) == wi[2]) w_d[j] = nw2;
                if (IW'(j) == wi[3]) w_d[j] = nw3;
            end
            idx_d = idx_q + IW'(4);
            if (idx_q + IW'(4) >= NWW) valid_d = 1'b1;
        end
    end

    // State registers; reset leaves a start pending for the first edge after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NW; j++) w_q[j] <= 32'h0;
            key_q   <= '0;
            idx_q   <= NWW;
            valid_q <= 1'b0;
            pend_q  <= 1'b1;
        end else begin
            w_q     <= w_d;
            if (start) key_q <= key;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            pend_q  <= 1'b0;
        end
    end

    for (genvar g = 0; g < NW; g++) begin : g_out
        assign w[(NW-1-g)*32 +: 32] = w_q[g];
    end
    assign valid = valid_q;
endmodule

// File: tb/tb_key_exp.sv
// tb_key_exp: three key_exp instances (AES-128/192/256) checked through a scoreboard.
module tb_key_exp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [127:0]  k128;
    logic [191:0]  k192;
    logic [255:0]  k256;
    logic [1407:0] w128;
    logic [1663:0] w192;
    logic [1919:0] w256;
    logic          v128, v192, v256;

    key_exp #(.nk(4), .nr(10)) u128 (.clk(clk), .rst(rst), .key(k128), .w(w128), .valid(v128));
    key_exp #(.nk(6), .nr(12)) u192 (.clk(clk), .rst(rst), .key(k192), .w(w192), .valid(v192));
    key_exp #(.nk(8), .nr(14)) u256 (.clk(clk), .rst(rst), .key(k256), .w(w256), .valid(v256));

    typedef struct {
        string          name;
        int             lat;
        logic [1919:0]  sched;
        int             j0;
        logic [127:0]   v0;
        int             j1;
        logic [127:0]   v1;
    } item_t;

    item_t q0[$], q1[$], q2[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int sc [3];
    logic [7:0] sb [256];

    localparam logic [127:0] KA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KB = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [191:0] K6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    // Straight sequential key expansion, S-box derived from GF(2^8) inverse + affine map
    task automatic model(input int nkm, input logic [255:0] k, output logic [1919:0] s);
        logic [31:0] wm [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nwm;
        nwm = 4 * (nkm + 7);
        rc  = 8'h01;
        for (int i = 0; i < nkm; i++) wm[i] = k[(nkm-1-i)*32 +: 32];
        for (int i = nkm; i < nwm; i++) begin
            t = wm[i-1];
            if (i % nkm == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end else if (nkm == 8 && i % nkm == 4) begin
                t = subw(t);
            end
            wm[i] = wm[i-nkm] ^ t;
        end
        s = '0;
        for (int i = 0; i < nwm; i++) s[(nwm-1-i)*32 +: 32] = wm[i];
    endtask

    function automatic logic [127:0] rk(input int d, input int j);
        case (d)
            0:       rk = w128[(10-j)*128 +: 128];
            1:       rk = w192[(12-j)*128 +: 128];
            default: rk = w256[(14-j)*128 +: 128];
        endcase
    endfunction

    // Push the expected outcome of an expansion whose start edge is the next rising edge
    task automatic push(input int d, input string name, input logic [255:0] k,
                        input int j0, input logic [127:0] v0, input int j1, input logic [127:0] v1);
        item_t it;
        it.name = name;
        it.j0 = j0; it.v0 = v0; it.j1 = j1; it.v1 = v1;
        it.lat = (d == 0) ? 11 : (d == 1) ? 13 : 14;
        model((d == 0) ? 4 : (d == 1) ? 6 : 8, k, it.sched);
        sc[d] = cyc + 1;
        case (d)
            0:       q0.push_back(it);
            1:       q1.push_back(it);
            default: q2.push_back(it);
        endcase
    endtask

    // Monitor: each rising valid pops one expected item for that instance
    logic [2:0] pv = 3'b000;
    always @(negedge clk) begin
        logic [2:0] vv;
        item_t      it;
        bit         got;
        int         nrd;
        vv = {v256, v192, v128};
        for (int d = 0; d < 3; d++) begin
            if (vv[d] && !pv[d]) begin
                got = 1'b0;
                case (d)
                    0:       if (q0.size() > 0) begin it = q0.pop_front(); got = 1'b1; end
                    1:       if (q1.size() > 0) begin it = q1.pop_front(); got = 1'b1; end
                    default: if (q2.size() > 0) begin it = q2.pop_front(); got = 1'b1; end
                endcase
                if (!got) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected valid: instance %0d at cycle %0d", d, cyc);
                end else begin
                    nrd = (d == 0) ? 10 : (d == 1) ? 12 : 14;
                    chk({it.name, " latency"}, 128'(cyc - sc[d] + 1), 128'(it.lat));
                    for (int j = 0; j <= nrd; j++)
                        chk($sformatf("%s model r%0d", it.name, j), rk(d, j), it.sched[(nrd-j)*128 +: 128]);
                    chk($sformatf("%s hand r%0d", it.name, it.j0), rk(d, it.j0), it.v0);
                    chk($sformatf("%s hand r%0d", it.name, it.j1), rk(d, it.j1), it.v1);
                end
            end
        end
        pv = vv;
    end

    initial begin
        logic [7:0] p, b;
        for (int x = 0; x < 256; x++) begin
            b = 8'(x);
            p = 8'h00;
            if (x != 0) begin
                p = 8'h01;
                for (int e = 0; e < 254; e++) p = gmul(p, b);
            end
            sb[x] = p ^ rotl(p, 1) ^ rotl(p, 2) ^ rotl(p, 3) ^ rotl(p, 4) ^ 8'h63;
        end

        k128 = KA; k192 = K6; k256 = K8;
        #1 rst = 1'b1;
        #2;
        chk("reset w128",  128'(|w128), 128'd0);
        chk("reset v128",  128'(v128),  128'd0);
        chk("reset w192",  128'(|w192), 128'd0);
        chk("reset v192",  128'(v192),  128'd0);
        chk("reset w256",  128'(|w256), 128'd0);
        chk("reset v256",  128'(v256),  128'd0);

        // First edge after release starts all three expansions
        @(negedge clk);
        rst = 1'b0;
        push(0, "aes128 A", 256'(KA), 1, 128'ha0fafe1788542cb123a339392a6c7605,
             10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        push(1, "aes192", 256'(K6), 0, K6[191:64], 1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        push(2, "aes256", K8, 0, K8[255:128], 2, 128'h9ba354118e6925afa51a8b5f2067fcde);
        #200;
        chk("v128 at 200ns", 128'(v128), 128'd1);
        chk("v192 at 200ns", 128'(v192), 128'd1);
        chk("v256 at 200ns", 128'(v256), 128'd1);

        // New key on a finished schedule
        @(negedge clk);
        k128 = KB;
        push(0, "aes128 B", 256'(KB), 0, KB, 1, 128'hdc9037b09b49dfe997fe723f388115a7);
        repeat (15) @(negedge clk);

        // Key change in the middle of an expansion
        k128 = KA;
        repeat (5) @(posedge clk);
        @(negedge clk);
        k128 = KB;
        push(0, "aes128 restart", 256'(KB), 0, KB, 1, 128'hdc9037b09b49dfe997fe723f388115a7);
        @(posedge clk);
        #1;
        chk("restart valid", 128'(v128), 128'd0);
        chk("restart r0", rk(0, 0), KB);
`ifdef KEYEXP_CLEAR_ON_RESTART_EN
        chk("restart word4", 128'(w128[39*32 +: 32]), 128'd0);
`else
        chk("restart word4", 128'(w128[39*32 +: 32]), 128'ha0fafe17);
`endif
        repeat (16) @(negedge clk);

        // Asynchronous reset between edges
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async w128", 128'(|w128), 128'd0);
        chk("async v128", 128'(v128),  128'd0);
        chk("async w192", 128'(|w192), 128'd0);
        chk("async v192", 128'(v192),  128'd0);
        chk("async w256", 128'(|w256), 128'd0);
        chk("async v256", 128'(v256),  128'd0);
        @(negedge clk);
        rst = 1'b0;
        push(0, "aes128 post-reset", 256'(KB), 0, KB, 1, 128'hdc9037b09b49dfe997fe723f388115a7);
        push(1, "aes192 post-reset", 256'(K6), 0, K6[191:64], 1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        push(2, "aes256 post-reset", K8, 0, K8[255:128], 2, 128'h9ba354118e6925afa51a8b5f2067fcde);
        repeat (22) @(negedge clk);

        chk("q128 drained", 128'(q0.size()), 128'd0);
        chk("q192 drained", 128'(q1.size()), 128'd0);
        chk("q256 drained", 128'(q2.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
